// File: rtl/bcd_conv_pkg.sv
// Shared types and sizing helpers for the shared binary-to-BCD conversion scheduler.
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int sr_w(input int bin_w, input int digits);
        return 4 * digits + bin_w;
    endfunction

    function automatic int cnt_w(input int bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Double-dabble digit correction, applied before each shift.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/dd_iter_core.sv
// Iterative double-dabble engine: one add-3 correction plus left shift per step.
module dd_iter_core
    import bcd_conv_pkg::*;
#(
    parameter int BIN_W      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BIN_W-1:0]        operand,
    input  logic                    step,
    output logic                    last,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int SR_W  = sr_w(BIN_W, BCD_DIGITS);
    localparam int CNT_W = cnt_w(BIN_W);

    logic [SR_W-1:0]  sr_q, sr_d, corr_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Correct every BCD digit from its pre-shift value; binary part passes through.
    always_comb begin
        corr_s = sr_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            corr_s[BIN_W + 4*d +: 4] = add3(sr_q[BIN_W + 4*d +: 4]);
        end
    end

    // Next shift-register and bit-counter values.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = {{(4*BCD_DIGITS){1'b0}}, operand};
            cnt_d = '0;
        end else if (step) begin
            sr_d  = corr_s << 1;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    // Datapath state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(BIN_W - 1));
    assign bcd  = sr_q[SR_W-1 -: 4*BCD_DIGITS];

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one iterative binary-to-BCD engine among NREQ requesters.
module bcd_conv_sched
    import bcd_conv_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int BIN_W      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BIN_W-1:0]   bin_in,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic                    done_valid,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);

    localparam int ID_W  = id_w(NREQ);
    localparam int IDX_W = ID_W + 1;
    localparam int BCD_W = 4 * BCD_DIGITS;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d, grant_q, grant_d, done_id_q, done_id_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              done_valid_q, done_valid_d, busy_q, busy_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, core_bcd_s;
    logic              gnt_found_s, load_s, step_s, last_s;
    logic [ID_W-1:0]   gnt_id_s;
    logic [IDX_W-1:0]  cand_s;
    logic [BIN_W-1:0]  operand_s;

    // Round-robin search: first active request at or after the pointer, wrapping.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_id_s    = rr_q;
        cand_s      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, rr_q} + IDX_W'(k);
            if (cand_s >= IDX_W'(NREQ)) begin
                cand_s = cand_s - IDX_W'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_found_s && req[cand_s[ID_W-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_id_s    = cand_s[ID_W-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign operand_s = bin_in[gnt_id_s*BIN_W +: BIN_W];

    dd_iter_core #(
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .operand (operand_s),
        .step    (step_s),
        .last    (last_s),
        .bcd     (core_bcd_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = gnt_found_s ? SHIFT : IDLE;
            SHIFT:   state_d = last_s ? DONE : SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: engine control and next values of the published result registers.
    always_comb begin
        load_s       = 1'b0;
        step_s       = 1'b0;
        rr_d         = rr_q;
        grant_d      = grant_q;
        ack_d        = '0;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        bcd_d        = bcd_q;
        case (state_q)
            IDLE: begin
                if (gnt_found_s) begin
                    load_s  = 1'b1;
                    grant_d = gnt_id_s;
                end else begin
                    load_s  = 1'b0;
                end
            end
            SHIFT: step_s = 1'b1;
            DONE: begin
                ack_d        = NREQ'(1) << grant_q;
                done_valid_d = 1'b1;
                done_id_d    = grant_q;
                bcd_d        = core_bcd_s;
                rr_d         = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
            end
            default: load_s = 1'b0;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Arbiter pointer, grant and published outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q         <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            bcd_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            bcd_q        <= bcd_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign done_valid = done_valid_q;
    assign done_id    = done_id_q;
    assign bcd_out    = bcd_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: directed requests, in-order result checking.
module tb_bcd_conv_sched;

    localparam int NREQ = 4;
    localparam int BIN_W = 8;
    localparam int BCD_DIGITS = 3;

    typedef struct {
        logic [1:0]  id;
        logic [11:0] bcd;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [31:0]      bin_in;
    logic [3:0]       ack;
    logic             busy;
    logic             done_valid;
    logic [1:0]       done_id;
    logic [11:0]      bcd_out;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   lat;

    bcd_conv_sched #(
        .NREQ       (NREQ),
        .BIN_W      (BIN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .bin_in     (bin_in),
        .ack        (ack),
        .busy       (busy),
        .done_valid (done_valid),
        .done_id    (done_id),
        .bcd_out    (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raise req[id] with operand val and queue the hand-computed result.
    task automatic issue(input int id, input logic [7:0] val, input logic [11:0] exp_bcd);
        exp_t e;
        bin_in[id*8 +: 8] = val;
        req[id] = 1'b1;
        e.id = 2'(id);
        e.bcd = exp_bcd;
        exp_q.push_back(e);
    endtask

    // Requesters drop their request on seeing ack; wait until all are served.
    task automatic wait_served();
        int cyc = 0;
        while (req != 4'b0000 && cyc < 400) begin
            @(negedge clk);
            req = req & ~ack;
            cyc++;
        end
        check("wait_served", 32'(req), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare each published result against the scoreboard head.
    always @(negedge clk) begin
        if (rst && done_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_id", 32'(done_id), 32'(mon_e.id));
                check("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
                check("ack_onehot", 32'(ack), 32'd1 << mon_e.id);
            end
        end else if (rst && ack != 4'b0000) begin
            check("ack_without_done", 32'(ack), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req = 4'b0000;
        bin_in = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_bcd_out", 32'(bcd_out), 32'd0);

        // Single request: 255 with latency measured in negedges after the request.
        issue(0, 8'd255, 12'h255);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) check("busy_in_shift", 32'(busy), 32'd1);
        end while (!done_valid && lat < 50);
        check("latency", 32'(lat), 32'(BIN_W + 2));
        req = req & ~ack;
        wait_served();

        issue(2, 8'd0, 12'h000);   wait_served();
        issue(2, 8'd9, 12'h009);   wait_served();
        issue(2, 8'd100, 12'h100); wait_served();
        repeat (3) @(negedge clk);
        check("bcd_hold", 32'(bcd_out), 32'h100);
        check("idle_busy", 32'(busy), 32'd0);

        // Serve 3 so the pointer wraps to 0, then all four at once.
        issue(3, 8'd42, 12'h042); wait_served();
        issue(0, 8'd10, 12'h010);
        issue(1, 8'd20, 12'h020);
        issue(2, 8'd30, 12'h030);
        issue(3, 8'd40, 12'h040);
        wait_served();

        // Pointer to 2, then req 0 and 1, with 3 joining mid-conversion.
        issue(1, 8'd123, 12'h123); wait_served();
        issue(0, 8'd55, 12'h055);
        issue(1, 8'd66, 12'h066);
        repeat (3) @(negedge clk);
        issue(3, 8'd77, 12'h077);
        wait_served();

        // Operand changed mid-conversion must not affect the result.
        issue(0, 8'd88, 12'h088);
        repeat (3) @(negedge clk);
        bin_in[7:0] = 8'd11;
        wait_served();

        // Asynchronous reset during the fourth shift cycle aborts the conversion.
        bin_in[15:8] = 8'd200;
        req[1] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd_out", 32'(bcd_out), 32'd0);
        check("abort_done_id", 32'(done_id), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        repeat (BIN_W + 4) @(negedge clk);
        issue(1, 8'd200, 12'h200);
        wait_served();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
